// File: rtl/alu_issue_stage.sv
// ID/EX issue slot: decodes a MIPS word into ALU opcode, operands, shamt and destination, behind a valid/ready handshake.
// Optional statistics counters are enabled by defining ALU_ISSUE_STATS_EN.
module alu_issue_stage #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned NB_CNT  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [31:0]        i_instr,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_OP-1:0]   o_alu_opcode,
    output logic [NB_DATA-1:0] o_operand1,
    output logic [NB_DATA-1:0] o_operand2,
    output logic [4:0]         o_shamt,
    output logic [4:0]         o_rd_addr,
    output logic               o_reg_write,
    output logic               o_illegal,
    output logic [NB_CNT-1:0]  o_issue_cnt,
    output logic [NB_CNT-1:0]  o_illegal_cnt
);

    localparam int unsigned NB_REG = 5;
    localparam int unsigned NB_IMM = 16;
    localparam int unsigned NB_FN  = 6;

    typedef struct packed {
        logic [NB_OP-1:0]   alu_opcode;
        logic [NB_DATA-1:0] operand1;
        logic [NB_DATA-1:0] operand2;
        logic [NB_REG-1:0]  shamt;
        logic [NB_REG-1:0]  rd_addr;
        logic               reg_write;
        logic               illegal;
    } slot_t;

    logic [NB_FN-1:0]  opcode;
    logic [NB_FN-1:0]  funct;
    logic [NB_REG-1:0] rt_addr;
    logic [NB_REG-1:0] rd_field;
    logic [NB_IMM-1:0] imm;
    logic              unused_rs_addr;

    assign opcode         = i_instr[31:26];
    assign funct          = i_instr[5:0];
    assign rt_addr        = i_instr[20:16];
    assign rd_field       = i_instr[15:11];
    assign imm            = i_instr[15:0];
    assign unused_rs_addr = ^i_instr[25:21];

    slot_t             dec_c;
    logic              legal_c;
    logic [NB_REG-1:0] dest_c;

    // Instruction decode; illegal encodings leave opcode and operands at zero.
    always_comb begin
        dec_c   = '0;
        legal_c = 1'b0;
        dest_c  = rt_addr;
        if (opcode == '0) begin
            dest_c = rd_field;
            case (funct)
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
                    legal_c        = 1'b1;
                    dec_c.operand1 = i_rt_data;
                    dec_c.operand2 = i_rs_data;
                end
                6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
                    legal_c        = 1'b1;
                    dec_c.operand1 = i_rs_data;
                    dec_c.operand2 = i_rt_data;
                end
                default: legal_c = 1'b0;
            endcase
            if (legal_c) begin
                dec_c.alu_opcode = NB_OP'(funct);
            end
        end else if (opcode[5:3] == 3'b001) begin
            legal_c          = 1'b1;
            dec_c.alu_opcode = NB_OP'(opcode);
            dec_c.operand1   = i_rs_data;
            dec_c.operand2   = opcode[2] ? {{(NB_DATA-NB_IMM){1'b0}}, imm}
                                         : {{(NB_DATA-NB_IMM){imm[NB_IMM-1]}}, imm};
        end
        dec_c.shamt     = i_instr[10:6];
        dec_c.rd_addr   = dest_c;
        dec_c.illegal   = !legal_c;
        dec_c.reg_write = legal_c && (dest_c != '0);
    end

    slot_t slot;
    logic  load_c;

    assign o_ready = !o_valid || i_ready;
    assign load_c  = i_valid && o_ready;

    // Slot register: flush beats load; flush only clears valid, payload is kept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            slot    <= '0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
        end else if (load_c) begin
            o_valid <= 1'b1;
            slot    <= dec_c;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

    assign o_alu_opcode = slot.alu_opcode;
    assign o_operand1   = slot.operand1;
    assign o_operand2   = slot.operand2;
    assign o_shamt      = slot.shamt;
    assign o_rd_addr    = slot.rd_addr;
    assign o_reg_write  = slot.reg_write;
    assign o_illegal    = slot.illegal;

`ifdef ALU_ISSUE_STATS_EN
    logic [NB_CNT-1:0] issue_cnt;
    logic [NB_CNT-1:0] illegal_cnt;
    logic              handshake_c;

    assign handshake_c = o_valid && i_ready;

    // Saturating handshake counters, untouched by flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            issue_cnt   <= '0;
            illegal_cnt <= '0;
        end else if (handshake_c) begin
            if (issue_cnt != '1) begin
                issue_cnt <= issue_cnt + NB_CNT'(1);
            end
            if (o_illegal && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + NB_CNT'(1);
            end
        end
    end

    assign o_issue_cnt   = issue_cnt;
    assign o_illegal_cnt = illegal_cnt;
`else
    assign o_issue_cnt   = '0;
    assign o_illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; counter checks adapt to ALU_ISSUE_STATS_EN.
module tb_alu_issue_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_rs_data;
    logic [31:0] i_rt_data;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [5:0]  o_alu_opcode;
    logic [31:0] o_operand1;
    logic [31:0] o_operand2;
    logic [4:0]  o_shamt;
    logic [4:0]  o_rd_addr;
    logic        o_reg_write;
    logic        o_illegal;
    logic [15:0] o_issue_cnt;
    logic [15:0] o_illegal_cnt;

    int total = 0;
    int bad   = 0;

    alu_issue_stage dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_instr(i_instr), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
        .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_alu_opcode(o_alu_opcode), .o_operand1(o_operand1), .o_operand2(o_operand2),
        .o_shamt(o_shamt), .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write),
        .o_illegal(o_illegal), .o_issue_cnt(o_issue_cnt), .o_illegal_cnt(o_illegal_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", o_valid); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h exp=1", o_ready); end
        total++; if (o_alu_opcode !== 6'h00) begin bad++; $display("FAIL reset_opcode got=%0h exp=0", o_alu_opcode); end
        total++; if (o_operand1 !== 32'h0 || o_operand2 !== 32'h0) begin bad++; $display("FAIL reset_operands got=%0h/%0h exp=0/0", o_operand1, o_operand2); end
        total++; if (o_rd_addr !== 5'd0 || o_reg_write !== 1'b0 || o_illegal !== 1'b0) begin bad++; $display("FAIL reset_flags got rd=%0d rw=%0b il=%0b exp=0", o_rd_addr, o_reg_write, o_illegal); end
        total++; if (o_issue_cnt !== 16'h0 || o_illegal_cnt !== 16'h0) begin bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", o_issue_cnt, o_illegal_cnt); end
    endtask

    task automatic test_addi();
        i_instr = 32'h2109FFFF; i_rs_data = 32'd5; i_rt_data = 32'hDEAD_BEEF; i_valid = 1'b1; i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0b exp=1", o_valid); end
        total++; if (o_alu_opcode !== 6'h08) begin bad++; $display("FAIL addi_opcode got=%0h exp=08", o_alu_opcode); end
        total++; if (o_operand1 !== 32'd5) begin bad++; $display("FAIL addi_op1 got=%0h exp=5", o_operand1); end
        total++; if (o_operand2 !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_op2 got=%0h exp=ffffffff", o_operand2); end
        total++; if (o_rd_addr !== 5'd9 || o_reg_write !== 1'b1 || o_illegal !== 1'b0) begin bad++; $display("FAIL addi_dest got rd=%0d rw=%0b il=%0b exp rd=9 rw=1 il=0", o_rd_addr, o_reg_write, o_illegal); end
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL addi_drain got=%0b exp=0", o_valid); end
    endtask

    task automatic test_ori_lui();
        i_instr = 32'h35098000; i_rs_data = 32'h0000_00F0; i_valid = 1'b1; i_ready = 1'b1;
        tick();
        total++; if (o_alu_opcode !== 6'h0D || o_operand2 !== 32'h00008000 || o_rd_addr !== 5'd9) begin bad++; $display("FAIL ori got op=%0h op2=%0h rd=%0d exp op=0d op2=8000 rd=9", o_alu_opcode, o_operand2, o_rd_addr); end
        total++; if (o_operand1 !== 32'h000000F0) begin bad++; $display("FAIL ori_op1 got=%0h exp=f0", o_operand1); end
        i_instr = 32'h3C091234; i_rs_data = 32'h0;
        tick();
        i_valid = 1'b0;
        total++; if (o_alu_opcode !== 6'h0F || o_operand2 !== 32'h00001234 || o_reg_write !== 1'b1) begin bad++; $display("FAIL lui got op=%0h op2=%0h rw=%0b exp op=0f op2=1234 rw=1", o_alu_opcode, o_operand2, o_reg_write); end
        tick();
    endtask

    task automatic test_rtype();
        i_instr = 32'h00095103; i_rs_data = 32'h0000_0011; i_rt_data = 32'h80000000; i_valid = 1'b1; i_ready = 1'b1;
        tick();
        total++; if (o_alu_opcode !== 6'h03 || o_operand1 !== 32'h80000000 || o_operand2 !== 32'h11) begin bad++; $display("FAIL sra got op=%0h op1=%0h op2=%0h exp op=03 op1=80000000 op2=11", o_alu_opcode, o_operand1, o_operand2); end
        total++; if (o_shamt !== 5'd4 || o_rd_addr !== 5'd10) begin bad++; $display("FAIL sra_fields got sh=%0d rd=%0d exp sh=4 rd=10", o_shamt, o_rd_addr); end
        // add $3,$1,$2 back-to-back behind the shift
        i_instr = 32'h00221820; i_rs_data = 32'h0000_0001; i_rt_data = 32'h0000_0002;
        tick();
        total++; if (o_valid !== 1'b1 || o_alu_opcode !== 6'h20 || o_operand1 !== 32'h1 || o_operand2 !== 32'h2 || o_rd_addr !== 5'd3) begin bad++; $display("FAIL add got v=%0b op=%0h op1=%0h op2=%0h rd=%0d exp v=1 op=20 op1=1 op2=2 rd=3", o_valid, o_alu_opcode, o_operand1, o_operand2, o_rd_addr); end
        i_instr = 32'h00000000;
        tick();
        i_valid = 1'b0;
        total++; if (o_valid !== 1'b1 || o_reg_write !== 1'b0 || o_illegal !== 1'b0 || o_alu_opcode !== 6'h00) begin bad++; $display("FAIL nop got v=%0b rw=%0b il=%0b op=%0h exp v=1 rw=0 il=0 op=0", o_valid, o_reg_write, o_illegal, o_alu_opcode); end
        tick();
    endtask

    task automatic test_backpressure();
        i_instr = 32'h2109FFFF; i_rs_data = 32'd5; i_valid = 1'b1; i_ready = 1'b0;
        tick();
        i_instr = 32'h35098000; i_rs_data = 32'd7;
        for (int c = 0; c < 3; c++) begin
            total++; if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_alu_opcode !== 6'h08 || o_operand1 !== 32'd5) begin bad++; $display("FAIL stall_%0d got rdy=%0b v=%0b op=%0h op1=%0h exp rdy=0 v=1 op=08 op1=5", c, o_ready, o_valid, o_alu_opcode, o_operand1); end
            tick();
        end
        i_ready = 1'b1;
        #1;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%0b exp=1", o_ready); end
        tick();
        i_valid = 1'b0;
        total++; if (o_valid !== 1'b1 || o_alu_opcode !== 6'h0D || o_operand1 !== 32'd7) begin bad++; $display("FAIL stall_next got v=%0b op=%0h op1=%0h exp v=1 op=0d op1=7", o_valid, o_alu_opcode, o_operand1); end
        tick();
    endtask

    task automatic test_illegal();
        i_rst_n = 1'b0; #1; i_rst_n = 1'b1; tick();
        i_instr = 32'h8D090000; i_rs_data = 32'h1234; i_rt_data = 32'h5678; i_valid = 1'b1; i_ready = 1'b1;
        tick();
        total++; if (o_valid !== 1'b1 || o_illegal !== 1'b1 || o_reg_write !== 1'b0 || o_alu_opcode !== 6'h00 || o_operand1 !== 32'h0 || o_operand2 !== 32'h0) begin bad++; $display("FAIL lw got v=%0b il=%0b rw=%0b op=%0h op1=%0h op2=%0h exp v=1 il=1 rw=0 op=0 op1=0 op2=0", o_valid, o_illegal, o_reg_write, o_alu_opcode, o_operand1, o_operand2); end
        i_instr = 32'h03E00008;
        tick();
        i_valid = 1'b0;
        total++; if (o_valid !== 1'b1 || o_illegal !== 1'b1 || o_reg_write !== 1'b0 || o_alu_opcode !== 6'h00) begin bad++; $display("FAIL jr got v=%0b il=%0b rw=%0b op=%0h exp v=1 il=1 rw=0 op=0", o_valid, o_illegal, o_reg_write, o_alu_opcode); end
        tick();
`ifdef ALU_ISSUE_STATS_EN
        total++; if (o_illegal_cnt !== 16'd2 || o_issue_cnt !== 16'd2) begin bad++; $display("FAIL illegal_cnt got ill=%0d iss=%0d exp ill=2 iss=2", o_illegal_cnt, o_issue_cnt); end
`else
        total++; if (o_illegal_cnt !== 16'd0 || o_issue_cnt !== 16'd0) begin bad++; $display("FAIL cnt_tied got ill=%0d iss=%0d exp 0/0", o_illegal_cnt, o_issue_cnt); end
`endif
    endtask

    task automatic test_flush_reset();
        i_instr = 32'h2109FFFF; i_rs_data = 32'd5; i_valid = 1'b1; i_ready = 1'b0;
        tick();
        i_valid = 1'b0; i_flush = 1'b1;
        tick();
        total++; if (o_valid !== 1'b0 || o_alu_opcode !== 6'h08 || o_operand1 !== 32'd5) begin bad++; $display("FAIL flush got v=%0b op=%0h op1=%0h exp v=0 op=08 op1=5", o_valid, o_alu_opcode, o_operand1); end
        i_instr = 32'h35098000; i_valid = 1'b1;
        tick();
        i_flush = 1'b0;
        total++; if (o_valid !== 1'b0 || o_alu_opcode !== 6'h08) begin bad++; $display("FAIL flush_drop got v=%0b op=%0h exp v=0 op=08", o_valid, o_alu_opcode); end
        i_instr = 32'h2109FFFF;
        tick();
        i_valid = 1'b0;
        tick();
`ifdef ALU_ISSUE_STATS_EN
        total++; if (o_issue_cnt !== 16'd2) begin bad++; $display("FAIL flush_cnt got=%0d exp=2", o_issue_cnt); end
`endif
        i_rst_n = 1'b0;
        #1;
        total++; if (o_valid !== 1'b0 || o_alu_opcode !== 6'h00 || o_operand1 !== 32'h0 || o_operand2 !== 32'h0 || o_rd_addr !== 5'd0 || o_reg_write !== 1'b0) begin bad++; $display("FAIL async_reset got v=%0b op=%0h op1=%0h op2=%0h rd=%0d rw=%0b exp all 0", o_valid, o_alu_opcode, o_operand1, o_operand2, o_rd_addr, o_reg_write); end
        total++; if (o_issue_cnt !== 16'h0 || o_illegal_cnt !== 16'h0) begin bad++; $display("FAIL async_reset_cnt got=%0d/%0d exp=0/0", o_issue_cnt, o_illegal_cnt); end
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_instr = '0; i_rs_data = '0; i_rt_data = '0;
        i_flush = 1'b0; i_ready = 1'b0;
        tick(); tick();
        test_reset();
        i_rst_n = 1'b1;
        tick();
        test_addi();
        test_ori_lui();
        test_rtype();
        test_backpressure();
        test_illegal();
        test_flush_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
